// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the load/store alignment unit.
// Op codes, FSM states, access sizes and alignment checks.
package mem_pkg;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_e;

  function automatic logic is_store(
    input logic [2:0] op
  );
    return op >= OP_SW;
  endfunction

  function automatic logic [1:0] op_size(
    input logic [2:0] op
  );
    logic [1:0] sz;
    case (op)
      OP_LW, OP_SW:         sz = SZ_W;
      OP_LH, OP_LHU, OP_SH: sz = SZ_H;
      default:              sz = SZ_B;
    endcase
    return sz;
  endfunction

  function automatic logic op_signed(
    input logic [2:0] op
  );
    return (op == OP_LH) || (op == OP_LB);
  endfunction

  function automatic logic is_aligned(
    input logic [2:0] op,
    input logic [1:0] a
  );
    logic ok;
    case (op_size(op))
      SZ_W:    ok = (a == 2'b00);
      SZ_H:    ok = ~a[0];
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lane_extend.sv
// Lane extract with sign/zero extension for loads,
// and lane merge into a read word for narrow stores.
module lane_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [31:0] wdata,
  output logic [31:0] ext,
  output logic [31:0] merged
);

  logic [7:0]  b_v;
  logic [15:0] h_v;
  logic [4:0]  b_sh;
  logic [4:0]  h_sh;

  assign b_sh = {lane, 3'b000};
  assign h_sh = {lane[1], 4'b0000};
  assign b_v  = word[b_sh +: 8];
  assign h_v  = word[h_sh +: 16];

  // extension of the selected lane and merge of new data into it
  always_comb begin
    ext    = word;
    merged = word;
    case (size)
      SZ_B: begin
        ext = {{24{sign & b_v[7]}}, b_v};
        merged[b_sh +: 8] = wdata[7:0];
      end
      SZ_H: begin
        ext = {{16{sign & h_v[15]}}, h_v};
        merged[h_sh +: 16] = wdata[15:0];
      end
      default: begin
        ext    = word;
        merged = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_align_unit.sv
// Load/store alignment unit: byte/half/word loads with extension,
// read-modify-write narrow stores, misalignment rejection.
module load_store_align_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int MEM_LATENCY   = 1,
  parameter int LITTLE_ENDIAN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_wr,
  output logic [31:0]       load_data,
  output logic              busy,
  output logic              done,
  output logic              misalign
);

  localparam logic [3:0] LAT_INIT = 4'(MEM_LATENCY - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       sd_q, sd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              mem_wr_q, mem_wr_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              misalign_q, misalign_d;

  logic [1:0]  lane_phys;
  logic [31:0] ext_w;
  logic [31:0] merged_w;

  assign lane_phys = (LITTLE_ENDIAN != 0) ? lane_q : ~lane_q;

  lane_extend u_lane (
    .word   (mem_rdata),
    .lane   (lane_phys),
    .size   (op_size(op_q)),
    .sign   (op_signed(op_q)),
    .wdata  (sd_q),
    .ext    (ext_w),
    .merged (merged_w)
  );

  // next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    lane_d      = lane_q;
    sd_d        = sd_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wr_d    = 1'b0;
    load_data_d = load_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    misalign_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          busy_d = 1'b1;
          op_d   = op;
          lane_d = addr[1:0];
          sd_d   = store_data;
          if (!is_aligned(op, addr[1:0])) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            misalign_d = 1'b1;
          end else begin
            mem_addr_d = {addr[ADDR_W-1:2], 2'b00};
            if (op == OP_SW) begin
              state_d     = S_WRITE;
              mem_wr_d    = 1'b1;
              mem_wdata_d = store_data;
            end else begin
              state_d = S_WAIT;
              cnt_d   = LAT_INIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          if (is_store(op_q)) begin
            state_d     = S_WRITE;
            mem_wr_d    = 1'b1;
            mem_wdata_d = merged_w;
          end else begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            load_data_d = ext_w;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WRITE: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      lane_q      <= '0;
      sd_q        <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_q    <= 1'b0;
      load_data_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      lane_q      <= lane_d;
      sd_q        <= sd_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_q    <= mem_wr_d;
      load_data_q <= load_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      misalign_q  <= misalign_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr    = mem_wr_q;
  assign load_data = load_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign misalign  = misalign_q;

endmodule

// File: doc/load_store_align_unit.md
Name: load_store_align_unit

Overview:
- Parametrised successor to the processor's load-size unit, covering both loads and stores.
- Accepts a memory operation from the multicycle control unit and drives the word-addressed data memory.
- Loads (byte/half/word): extracts the addressed lane and sign- or zero-extends it.
- Stores (byte/half/word): narrow stores use read-modify-write; word stores write directly. Misaligned accesses are flagged and never reach memory.

Parameters:
- ADDR_W, 32, byte-address width.
- MEM_LATENCY, 1, cycles from mem_addr valid to mem_rdata valid; legal range 1..15.
- LITTLE_ENDIAN, 1, 1 = byte 0 at bits [7:0]; 0 = byte 0 at bits [31:24].

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- op  in  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB.
- addr  in  ADDR_W  byte address.
- store_data  in  32  store source register value.
- mem_rdata  in  32  memory read word.
- mem_addr  out  ADDR_W  word-aligned address, addr with bits [1:0] forced to 00.
- mem_wdata  out  32  write word.
- mem_wr  out  1  memory write enable.
- load_data  out  32  extended load result, held until the next load completes.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.
- misalign  out  1  valid with done; 1 = access rejected.

Behaviour:
- Reset (asynchronous, reset=0):
  - state IDLE.
  - mem_addr, mem_wdata, load_data = 0.
  - mem_wr, busy, done, misalign = 0.
  - Applies immediately mid-operation; mem_wr drops without waiting for a clock edge.
  - No write is issued after reset release until a new start.
- States: IDLE, WAIT, WRITE, DONE.
- Accept (IDLE, start=1 at edge t): op, addr, store_data latched; later input changes are ignored. start is ignored while busy.
- Alignment rules:
  - Word ops need addr[1:0]=00.
  - Half ops need addr[0]=0.
  - Byte ops are always aligned.
- Misaligned at accept: go to DONE.
  - Cycle t+1: done=1, misalign=1, mem_wr=0.
  - load_data is unchanged; memory is untouched.
- Loads: WAIT for MEM_LATENCY cycles (t+1..t+L) with mem_addr driven and mem_wr=0.
  - At the edge ending the last WAIT cycle, load_data is registered.
  - done=1 in cycle t+L+1. Latency is L+1 cycles (2 by default).
  - Lane selection: byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend from the lane MSB. LBU/LHU zero-extend. LW passes the word through.
- SW: WRITE in cycle t+1 with mem_wdata=store_data and mem_wr=1; done in t+2.
- SB/SH: WAIT for L cycles, then WRITE in cycle t+L+1.
  - mem_wdata = mem_rdata with only the addressed lane replaced by store_data[7:0] or [15:0].
  - done in t+L+2.
- mem_wr is high only in WRITE, for exactly one cycle per store.
- DONE lasts one cycle, then IDLE.
  - busy is high in DONE; start during DONE is ignored.
  - Minimum issue interval = latency + 1.
- misalign=0 on every aligned completion. done, misalign and busy are registered.
- WAIT count uses a 4-bit counter loaded with MEM_LATENCY-1; it exits at 0.
- LITTLE_ENDIAN=0 mirrors lane indices (lane k maps to lane 3-k) for both extraction and merge.

Decomposition:
- Shared package mem_pkg:
  - op encodings (OP_LW..OP_SB);
  - state enum;
  - function is_store(op) and function is_aligned(op, addr[1:0]).
- Sub-module lane_extend: combinational extract/extend for loads plus merge for stores. Inputs: word, lane, size, signed flag, new data. Instantiated once.

Test Plan:
- LB addr=0x103, mem_rdata=0x80FF1234 (little-endian) -> done at t+2, load_data=0xFFFFFF80. LBU on the same -> 0x00000080.
- LH addr=0x102, mem_rdata=0x8001ABCD -> 0xFFFF8001. LHU addr=0x100 -> 0x0000ABCD. LW -> 0x8001ABCD.
- SB addr=0x201, store_data=0xAA, mem_rdata=0x11223344 -> single mem_wr pulse at t+2, mem_wdata=0x1122AA44, mem_addr=0x200, done at t+3.
- SW addr=0x204, store_data=0xDEADBEEF -> mem_wr at t+1 only, mem_wdata=0xDEADBEEF, done at t+2, no WAIT cycle.
- LW addr=0x102 and SH addr=0x101 -> done+misalign at t+1, mem_wr never high, load_data unchanged. Next aligned op returns misalign=0.
- reset low during SH WAIT -> busy=0 and mem_wr=0 immediately, no write ever issued. start asserted during busy/DONE -> ignored. MEM_LATENCY=3 -> LW done at t+4.
